// File: rtl/audio_dac_i2s_tx.sv
// I2S playback serializer: Avalon-side frame FIFO feeding DACDAT, timed by codec-mastered BCLK/DACLRCK.
// Optional DAC_HOLD_LAST_EN: an underrun retransmits the last popped frame instead of silence.
module audio_dac_i2s_tx #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  input  logic                          aud_bclk,
  input  logic                          aud_daclrck,
  output logic                          aud_dacdat,
  input  logic                          enable,
  input  logic                          snd_valid,
  output logic                          snd_ready,
  input  logic [DATA_WIDTH-1:0]         snd_left,
  input  logic [DATA_WIDTH-1:0]         snd_right,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun
);

  localparam int unsigned ADDR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned LEVEL_W = ADDR_W + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] left;
    logic [DATA_WIDTH-1:0] right;
  } frame_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [1:0] bclk_sync;
  logic [1:0] lrck_sync;
  logic       bclk_d;
  logic       lrck_d;
  logic       bclk_fall_c;
  logic       lrck_fall_c;
  logic       lrck_rise_c;

  logic       frame_start_c;
  logic       right_load_c;
  logic       shift_c;

  frame_t              mem [0:FIFO_DEPTH-1];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic                push_c;
  logic                pop_c;
  logic [LEVEL_W-1:0]  level_next_c;
  frame_t              frame_in_c;
  frame_t              head_c;
  frame_t              fill_c;

  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] hold;

  // Two-flop synchronizers plus one edge-detect stage for both codec clocks
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      bclk_sync <= 2'b00;
      lrck_sync <= 2'b00;
      bclk_d    <= 1'b0;
      lrck_d    <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[0], aud_bclk};
      lrck_sync <= {lrck_sync[0], aud_daclrck};
      bclk_d    <= bclk_sync[1];
      lrck_d    <= lrck_sync[1];
    end
  end

  assign bclk_fall_c = bclk_d & ~bclk_sync[1];
  assign lrck_fall_c = lrck_d & ~lrck_sync[1];
  assign lrck_rise_c = ~lrck_d & lrck_sync[1];

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Word loads outrank a coincident BCLK fall, so the MSB leaves one BCLK after the LRCK edge
  always_comb begin
    state_next    = state;
    frame_start_c = 1'b0;
    right_load_c  = 1'b0;
    shift_c       = 1'b0;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_next = ALIGN;
        end
        ALIGN: begin
          if (lrck_fall_c) begin
            state_next    = RUN;
            frame_start_c = 1'b1;
          end
        end
        RUN: begin
          if (lrck_fall_c) begin
            frame_start_c = 1'b1;
          end else if (lrck_rise_c) begin
            right_load_c = 1'b1;
          end else if (bclk_fall_c) begin
            shift_c = 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign frame_in_c   = '{left: snd_left, right: snd_right};
  assign head_c       = mem[rd_ptr];
  assign push_c       = snd_valid & snd_ready;
  assign pop_c        = frame_start_c & (fifo_level != '0);
  assign level_next_c = fifo_level + LEVEL_W'(push_c) - LEVEL_W'(pop_c);

  // Frame storage; no reset needed since pointers define validity
  always_ff @(posedge clk_clk) begin
    if (push_c) begin
      mem[wr_ptr] <= frame_in_c;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      snd_ready  <= 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      fifo_level <= level_next_c;
      snd_ready  <= (level_next_c != LEVEL_W'(FIFO_DEPTH));
    end
  end

`ifdef DAC_HOLD_LAST_EN
  frame_t last_frame;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      last_frame <= '0;
    end else if (pop_c) begin
      last_frame <= head_c;
    end
  end

  assign fill_c = last_frame;
`else
  assign fill_c = '0;
`endif

  // Serializer: left word loaded at frame start, right word parked in hold until LRCK rises
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      shreg      <= '0;
      hold       <= '0;
      aud_dacdat <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (!enable) begin
        shreg      <= '0;
        hold       <= '0;
        aud_dacdat <= 1'b0;
      end else if (frame_start_c) begin
        shreg    <= pop_c ? head_c.left  : fill_c.left;
        hold     <= pop_c ? head_c.right : fill_c.right;
        underrun <= ~pop_c;
      end else if (right_load_c) begin
        shreg <= hold;
      end else if (shift_c) begin
        aud_dacdat <= shreg[DATA_WIDTH-1];
        shreg      <= {shreg[DATA_WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_audio_dac_i2s_tx.sv
// Scoreboard bench for audio_dac_i2s_tx: a frame-level model predicts every DACDAT bit per BCLK fall.
module tb_audio_dac_i2s_tx;

  localparam int DW = 16;
  localparam int FD = 4;
  localparam int ABORT_K = 6;

  typedef struct packed {
    logic [DW-1:0] left;
    logic [DW-1:0] right;
  } frame_t;

  typedef struct {
    bit chk;
    bit val;
    int ch;
    int k;
  } exp_t;

  logic                   clk_clk = 1'b0;
  logic                   reset_reset_n;
  logic                   aud_bclk;
  logic                   aud_daclrck;
  logic                   aud_dacdat;
  logic                   enable;
  logic                   snd_valid;
  logic                   snd_ready;
  logic [DW-1:0]          snd_left;
  logic [DW-1:0]          snd_right;
  logic [$clog2(FD):0]    fifo_level;
  logic                   underrun;

  int checks = 0;
  int failures = 0;
  int underrun_cycles = 0;
  int exp_underruns = 0;

  exp_t   expq [$];
  frame_t mq [$];
  frame_t cur = '0;
  frame_t last = '0;
  bit     running = 1'b0;
  bit     en_model = 1'b0;

  audio_dac_i2s_tx #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clk_clk(clk_clk),
    .reset_reset_n(reset_reset_n),
    .aud_bclk(aud_bclk),
    .aud_daclrck(aud_daclrck),
    .aud_dacdat(aud_dacdat),
    .enable(enable),
    .snd_valid(snd_valid),
    .snd_ready(snd_ready),
    .snd_left(snd_left),
    .snd_right(snd_right),
    .fifo_level(fifo_level),
    .underrun(underrun)
  );

  always #10 clk_clk = ~clk_clk;

  always @(posedge clk_clk) if (underrun === 1'b1) underrun_cycles++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: each BCLK fall is answered on DACDAT three clk later
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge aud_bclk);
      repeat (3) @(posedge clk_clk);
      #1;
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dacdat_sb: no expectation queued at %0t", $time);
      end else begin
        e = expq.pop_front();
        if (e.chk) begin
          checks++;
          if (aud_dacdat !== e.val) begin
            failures++;
            $display("FAIL dacdat ch%0d bit%0d: got %0b expected %0b at %0t",
                     e.ch, e.k, aud_dacdat, e.val, $time);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  // Model of a left-channel start: pop, or underrun fill
  task automatic model_frame_start();
    if (en_model) begin
      running = 1'b1;
      if (mq.size() > 0) begin
        cur  = mq.pop_front();
        last = cur;
      end else begin
        exp_underruns++;
`ifdef DAC_HOLD_LAST_EN
        cur = last;
`else
        cur = '0;
`endif
      end
    end else begin
      running = 1'b0;
    end
  endtask

  task automatic push_exp(input int ch, input int k);
    exp_t e;
    logic [DW-1:0] w;
    w = (ch == 0) ? cur.left : cur.right;
    e.ch = ch;
    e.k  = k;
    if (!running) begin
      e.chk = 1'b1; e.val = 1'b0;
    end else if (k == 0) begin
      e.chk = 1'b0; e.val = 1'b0;
    end else if (k <= DW) begin
      e.chk = 1'b1; e.val = w[DW-k];
    end else begin
      e.chk = 1'b1; e.val = 1'b0;
    end
    expq.push_back(e);
  endtask

  task automatic do_abort(input int mode);
    @(negedge clk_clk);
    if (running) chk("pre_abort_dacdat", 32'(aud_dacdat), 32'(cur.left[DW-5]));
    if (mode == 1) begin
      enable = 1'b0;
      en_model = 1'b0;
      running = 1'b0;
      @(posedge clk_clk); #1;
      chk("abort_disable_dacdat", 32'(aud_dacdat), 32'd0);
    end else begin
      reset_reset_n = 1'b0;
      running = 1'b0;
      mq.delete();
      last = '0;
      #1;
      chk("abort_reset_dacdat", 32'(aud_dacdat), 32'd0);
      chk("abort_reset_ready", 32'(snd_ready), 32'd0);
      chk("abort_reset_level", 32'(fifo_level), 32'd0);
      repeat (2) @(negedge clk_clk);
      reset_reset_n = 1'b1;
      @(posedge clk_clk); #1;
      chk("abort_reset_ready_rise", 32'(snd_ready), 32'd1);
    end
  endtask

  // One stereo frame of 2*half BCLK cycles; LRCK changes together with a BCLK fall
  task automatic run_frame(input int half, input int abort_mode);
    for (int ch = 0; ch < 2; ch++) begin
      for (int k = 0; k < half; k++) begin
        if (ch == 0 && k == ABORT_K && abort_mode != 0) do_abort(abort_mode);
        @(negedge clk_clk);
        if (k == 0) begin
          aud_daclrck = (ch == 1);
          if (ch == 0) model_frame_start();
        end
        aud_bclk = 1'b0;
        push_exp(ch, k);
        repeat (4) @(negedge clk_clk);
        aud_bclk = 1'b1;
        repeat (4) @(negedge clk_clk);
      end
    end
  endtask

  task automatic write_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
    @(negedge clk_clk);
    chk("ready_before_write", 32'(snd_ready), 32'(mq.size() < FD));
    chk("level_before_write", 32'(fifo_level), 32'(mq.size()));
    snd_valid = 1'b1;
    snd_left  = l;
    snd_right = r;
    @(posedge clk_clk);
    if (mq.size() < FD) mq.push_back('{left: l, right: r});
    @(negedge clk_clk);
    snd_valid = 1'b0;
  endtask

  task automatic check_fifo(input string name);
    @(negedge clk_clk);
    chk({name, "_level"}, 32'(fifo_level), 32'(mq.size()));
    chk({name, "_ready"}, 32'(snd_ready), 32'(mq.size() < FD));
  endtask

  initial begin : stimulus
    reset_reset_n = 1'b0;
    enable = 1'b0;
    snd_valid = 1'b0;
    snd_left = '0;
    snd_right = '0;
    aud_bclk = 1'b1;
    aud_daclrck = 1'b1;
    repeat (2) @(negedge clk_clk);

    // Reset held while the codec clocks run
    run_frame(4, 0);
    @(negedge clk_clk);
    chk("reset_dacdat", 32'(aud_dacdat), 32'd0);
    chk("reset_ready", 32'(snd_ready), 32'd0);
    chk("reset_level", 32'(fifo_level), 32'd0);
    chk("reset_underrun", 32'(underrun), 32'd0);
    reset_reset_n = 1'b1;
    #1 chk("ready_at_release", 32'(snd_ready), 32'd0);
    @(posedge clk_clk); #1;
    chk("ready_after_release", 32'(snd_ready), 32'd1);

    enable = 1'b1;
    en_model = 1'b1;
    repeat (2) @(negedge clk_clk);

    // Single 64fs frame, then a frame followed by an underrun
    write_frame(16'h8001, 16'h7FFE);
    run_frame(32, 0);
    write_frame(16'hA5A5, 16'h5A5A);
    run_frame(32, 0);
    run_frame(32, 0);
    chk("underrun_pulses_1", 32'(underrun_cycles), 32'(exp_underruns));

    // FIFO full: fifth frame refused; one frame start frees a slot
    for (int i = 0; i < 5; i++) write_frame(16'($urandom), 16'($urandom));
    check_fifo("full");
    run_frame(32, 0);
    check_fifo("after_pop");
    for (int i = 0; i < 3; i++) run_frame(32, 0);

    // Disable after five left bits, then restart on the next LRCK fall
    write_frame(16'hF81F, 16'h1234);
    write_frame(16'hC3A1, 16'h8E71);
    run_frame(32, 1);
    check_fifo("kept_after_disable");
    @(negedge clk_clk);
    enable = 1'b1;
    en_model = 1'b1;
    repeat (2) @(negedge clk_clk);
    run_frame(32, 0);

    // Reset after five left bits; FIFO and hold state cleared
    write_frame(16'hF81F, 16'h4321);
    write_frame(16'h1111, 16'h2222);
    run_frame(32, 2);
    write_frame(16'h9AB7, 16'h6C05);
    run_frame(32, 0);

    // Short half-frame drops the unsent LSBs
    write_frame(16'hFFFF, 16'hB6D9);
    run_frame(12, 0);

    // Randomized traffic
    for (int it = 0; it < 20; it++) begin
      int nw;
      nw = $urandom_range(0, 2);
      for (int w = 0; w < nw; w++) write_frame(16'($urandom), 16'($urandom));
      run_frame($urandom_range(12, 34), 0);
    end

    for (int i = 0; i < 20 && expq.size() != 0; i++) @(posedge clk_clk);
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    chk("underrun_pulses_total", 32'(underrun_cycles), 32'(exp_underruns));
    check_fifo("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
